uart_tx_arb: RTL and testbench
==============================

UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 SHALL have parameter N, default 4: number of requesters (2..8).
REQ-002 SHALL have parameter HOLD_TIMEOUT, default 1000: idle-owner cycles before forced release (1..65535).
REQ-003 SHALL have ports:
  clk  input  1  system clock, all logic on rising edge
  rst  input  1  synchronous reset, active-high
  req_valid  input  N  requester i has a byte on its lane
  req_data  input  8*N  byte lane i = bits [8i+7:8i]
  req_last  input  N  byte on lane i ends requester i's packet
  req_ready  output  N  handshake; byte i accepted when req_valid[i] and req_ready[i] are both high
  tx_we  output  1  write strobe to transmitter
  tx_din  output  8  byte to transmitter
  tx_busy  input  1  transmitter frame in progress
  grant  output  N  one-hot current owner, all-zero when unowned
  active  output  1  high whenever state is not ARB
  timeout  output  1  one-cycle pulse on forced release
REQ-004 SHALL use one clock; reset is synchronous and active-high.

Function
REQ-005 SHALL implement states ARB, SEND, WAIT_START, WAIT_DONE.
REQ-006 ARB: when tx_busy=0 and any req_valid is high, SHALL register winner as owner, set grant to one-hot(owner), and go to SEND; otherwise stay.
REQ-007 Winner SHALL be the first set req_valid bit searching ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
REQ-008 req_ready SHALL be combinational: req_ready[owner] = (state==SEND && req_valid[owner] && !tx_busy); all other bits 0.
REQ-009 On a SEND handshake (cycle k) SHALL register tx_din = owner's byte, last_r = req_last[owner], tx_we=1 for cycle k+1 only, and go to WAIT_START.
REQ-010 WAIT_START: tx_we SHALL be 0 after its single cycle; on tx_busy=1 SHALL go to WAIT_DONE.
REQ-011 WAIT_DONE: on tx_busy=0, if last_r=1 SHALL release: grant=0, ptr=(owner+1) mod N, go to ARB. If last_r=0 SHALL go to SEND, owner unchanged.
REQ-012 While owned, requests from non-owners SHALL be ignored (no ready, no arbitration) until release.
REQ-013 In SEND, a 16-bit counter SHALL increment every cycle without a handshake and clear on handshake or state entry.
REQ-014 When the counter reaches HOLD_TIMEOUT-1 in SEND without a handshake, SHALL release as in REQ-011 and pulse timeout for exactly one cycle.
REQ-015 If handshake and timeout condition coincide, the handshake SHALL win; no timeout pulse.
REQ-016 tx_din SHALL hold its value until the next handshake.
REQ-017 ptr wrap SHALL be modulo N; owner N-1 releases to ptr=0.
REQ-018 At most one tx_we pulse SHALL occur per accepted byte; no tx_we without a handshake.
REQ-019 Throughput: the next SEND handshake of the same owner SHALL be possible in the cycle after WAIT_DONE observes tx_busy=0.

Reset
REQ-020 With rst=1 at a clock edge: state=ARB, tx_we=0, tx_din=0, grant=0, active=0, timeout=0, ptr=0, counter=0, last_r=0.
REQ-021 Reset mid-operation SHALL abandon ownership immediately; this block does not reset or abort the transmitter; after reset it SHALL not arbitrate until tx_busy=0.
REQ-022 req_ready SHALL be all-zero while rst=1.

Verification
REQ-023 Single byte: req_valid=0001, data 0x55, last=1, tx idle -> grant=0001 next cycle, req_ready[0] for one cycle, tx_we one cycle with tx_din=0x55, release and ptr=1 after busy falls.
REQ-024 Round-robin: all four valid, single-byte packets -> service order 0,1,2,3,0 with ptr wrapping to 0.
REQ-025 Packet lock: req 2 sends 3 bytes (0xA1,0xA2,0xA3, last on third) while req 0,1 valid -> three tx_we strobes all from lane 2, grant stays 0100, then requester 3 or 0 per ptr=3.
REQ-026 Timeout: HOLD_TIMEOUT=8, owner drops req_valid after a non-last byte -> release and timeout pulse exactly 8 cycles after SEND entry, no extra tx_we.
REQ-027 Reset during WAIT_DONE with tx_busy held high -> outputs per REQ-020 next edge; no grant until tx_busy=0.
REQ-028 Handshake on the timeout cycle -> byte accepted, no timeout pulse, owner retained.

Source files
------------

// File: rtl/uart_tx_arb_if.sv
// Handshake bundle between N byte requesters, the arbiter and one UART transmitter.
// The master side drives requests and transmitter status; the slave side is the arbiter.
interface uart_tx_arb_if #(
  parameter int N = 4
);
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic           tx_we;
  logic [7:0]     tx_din;
  logic           tx_busy;
  logic [N-1:0]   grant;
  logic           active;
  logic           timeout;

  modport master (
    output req_valid, req_data, req_last, tx_busy,
    input  req_ready, tx_we, tx_din, grant, active, timeout
  );

  modport slave (
    input  req_valid, req_data, req_last, tx_busy,
    output req_ready, tx_we, tx_din, grant, active, timeout
  );
endinterface

// File: rtl/uart_tx_arb.sv
// Round-robin packet arbiter feeding one UART transmitter; an owner keeps the
// transmitter until its last byte or until it idles for HOLD_TIMEOUT cycles.
module uart_tx_arb #(
  parameter int N            = 4,
  parameter int HOLD_TIMEOUT = 1000
) (
  input logic           clk,
  input logic           rst,
  uart_tx_arb_if.slave  arb
);
  localparam int W = $clog2(N);
  localparam logic [15:0] HOLD_LIM = 16'(HOLD_TIMEOUT - 1);

  typedef enum logic [1:0] {ARB, SEND, WAIT_START, WAIT_DONE} state_t;

  state_t         state;
  logic [W-1:0]   owner;
  logic [W-1:0]   ptr;
  logic [15:0]    hold_cnt;
  logic           last_r;
  logic           tx_we_r;
  logic [7:0]     tx_din_r;
  logic [N-1:0]   grant_r;
  logic           timeout_r;
  logic           hs;
  logic           any_req;
  logic [W-1:0]   winner;
  logic [N-1:0]   ready_c;

  function automatic logic [W-1:0] next_idx(input logic [W-1:0] i);
    if (int'(i) == N - 1) return '0;
    return i + W'(1);
  endfunction

  // Scan from the highest rotated offset down so the lowest offset from p wins.
  function automatic logic [W-1:0] pick(input logic [N-1:0] v, input logic [W-1:0] p);
    logic [W-1:0] w;
    int j;
    w = p;
    for (int i = N - 1; i >= 0; i--) begin
      j = int'(p) + i;
      if (j >= N) j = j - N;
      if (v[W'(j)]) w = W'(j);
    end
    return w;
  endfunction

  function automatic logic [N-1:0] onehot(input logic [W-1:0] i);
    logic [N-1:0] m;
    m = '0;
    m[i] = 1'b1;
    return m;
  endfunction

  assign hs      = (state == SEND) && arb.req_valid[owner] && !arb.tx_busy;
  assign any_req = |arb.req_valid;
  assign winner  = pick(arb.req_valid, ptr);

  always_comb begin
    ready_c = '0;
    if (!rst && hs) ready_c[owner] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ARB;
      owner     <= '0;
      ptr       <= '0;
      hold_cnt  <= '0;
      last_r    <= 1'b0;
      tx_we_r   <= 1'b0;
      tx_din_r  <= '0;
      grant_r   <= '0;
      timeout_r <= 1'b0;
    end else begin
      tx_we_r   <= 1'b0;
      timeout_r <= 1'b0;
      case (state)
        ARB: begin
          if (!arb.tx_busy && any_req) begin
            owner    <= winner;
            grant_r  <= onehot(winner);
            hold_cnt <= '0;
            state    <= SEND;
          end
        end
        SEND: begin
          // A handshake on the limit cycle takes priority over the forced release.
          if (hs) begin
            tx_din_r <= arb.req_data[8*owner +: 8];
            last_r   <= arb.req_last[owner];
            tx_we_r  <= 1'b1;
            hold_cnt <= '0;
            state    <= WAIT_START;
          end else if (hold_cnt == HOLD_LIM) begin
            grant_r   <= '0;
            ptr       <= next_idx(owner);
            timeout_r <= 1'b1;
            hold_cnt  <= '0;
            state     <= ARB;
          end else begin
            hold_cnt <= hold_cnt + 16'd1;
          end
        end
        WAIT_START: begin
          if (arb.tx_busy) state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (!arb.tx_busy) begin
            if (last_r) begin
              grant_r <= '0;
              ptr     <= next_idx(owner);
              state   <= ARB;
            end else begin
              hold_cnt <= '0;
              state    <= SEND;
            end
          end
        end
        default: state <= ARB;
      endcase
    end
  end

  assign arb.req_ready = ready_c;
  assign arb.tx_we     = tx_we_r;
  assign arb.tx_din    = tx_din_r;
  assign arb.grant     = grant_r;
  assign arb.active    = (state != ARB);
  assign arb.timeout   = timeout_r;
endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb (N=4, HOLD_TIMEOUT=8); the transmitter busy line
// is driven by hand so every cycle's expected outputs are known in advance.
module tb_uart_tx_arb;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  uart_tx_arb_if #(.N(4)) bus ();

  uart_tx_arb #(.N(4), .HOLD_TIMEOUT(8)) dut (
    .clk (clk),
    .rst (rst),
    .arb (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ARB -> SEND: grant appears one edge after the request is seen.
  task automatic arb_win(input string tag, input logic [3:0] own);
    tick();
    check({tag, "_grant"}, bus.grant, own);
    check({tag, "_active"}, bus.active, 1);
  endtask

  // One byte from SEND through the transmitter frame; returns just after busy falls.
  task automatic byte_xfer(input string tag, input logic [3:0] own, input logic [7:0] din);
    #1;
    check({tag, "_ready"}, bus.req_ready, own);
    tick();
    check({tag, "_we"}, bus.tx_we, 1);
    check({tag, "_din"}, bus.tx_din, din);
    check({tag, "_ready_ws"}, bus.req_ready, 0);
    bus.tx_busy = 1'b1;
    tick();
    check({tag, "_we_once"}, bus.tx_we, 0);
    check({tag, "_grant_hold"}, bus.grant, own);
    bus.tx_busy = 1'b0;
    tick();
  endtask

  initial begin
    int order [5] = '{0, 1, 2, 3, 0};
    logic [3:0] oh;
    total = 0;
    bad   = 0;
    rst = 1'b1;
    bus.req_valid = 4'b1111;
    bus.req_data  = '0;
    bus.req_last  = '0;
    bus.tx_busy   = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_we", bus.tx_we, 0);
    check("rst_din", bus.tx_din, 0);
    check("rst_grant", bus.grant, 0);
    check("rst_active", bus.active, 0);
    check("rst_timeout", bus.timeout, 0);
    check("rst_ready", bus.req_ready, 0);

    // Single byte from requester 0
    bus.req_valid = 4'b0001;
    bus.req_data[7:0] = 8'h55;
    bus.req_last  = 4'b0001;
    rst = 1'b0;
    arb_win("single", 4'b0001);
    byte_xfer("single", 4'b0001, 8'h55);
    check("single_rel_grant", bus.grant, 0);
    check("single_rel_active", bus.active, 0);
    bus.req_valid = 4'b0000;

    // Round robin from ptr=0
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) bus.req_data[8*i +: 8] = 8'h10 + 8'(i);
    bus.req_last  = 4'b1111;
    bus.req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      oh = 4'b0001 << order[k];
      arb_win($sformatf("rr%0d", k), oh);
      byte_xfer($sformatf("rr%0d", k), oh, 8'h10 + 8'(order[k]));
      check($sformatf("rr%0d_rel", k), bus.grant, 0);
    end

    // Packet lock: ptr=1, requester 2 wins alone, then 0 and 1 join
    bus.req_valid = 4'b0100;
    bus.req_last  = 4'b0011;
    bus.req_data[7:0]   = 8'h20;
    bus.req_data[15:8]  = 8'h21;
    bus.req_data[23:16] = 8'hA1;
    arb_win("pkt", 4'b0100);
    bus.req_valid = 4'b0111;
    byte_xfer("pkt_b1", 4'b0100, 8'hA1);
    bus.req_data[23:16] = 8'hA2;
    check("pkt_lock1", bus.grant, 4'b0100);
    byte_xfer("pkt_b2", 4'b0100, 8'hA2);
    bus.req_data[23:16] = 8'hA3;
    bus.req_last[2] = 1'b1;
    check("pkt_lock2", bus.grant, 4'b0100);
    byte_xfer("pkt_b3", 4'b0100, 8'hA3);
    check("pkt_rel", bus.grant, 0);
    bus.req_valid = 4'b0011;
    arb_win("pkt_next", 4'b0001);
    byte_xfer("pkt_next", 4'b0001, 8'h20);
    bus.req_valid = 4'b0000;

    // Timeout: requester 1 sends a non-last byte then goes quiet
    bus.req_valid = 4'b0010;
    bus.req_data[15:8] = 8'h33;
    bus.req_last  = 4'b0000;
    arb_win("to", 4'b0010);
    byte_xfer("to", 4'b0010, 8'h33);
    bus.req_valid = 4'b0000;
    for (int k = 1; k <= 7; k++) begin
      tick();
      check($sformatf("to_wait%0d", k), {bus.timeout, bus.tx_we, bus.grant}, 6'b00_0010);
    end
    tick();
    check("to_pulse", bus.timeout, 1);
    check("to_grant", bus.grant, 0);
    check("to_active", bus.active, 0);
    check("to_no_we", bus.tx_we, 0);
    tick();
    check("to_pulse_end", bus.timeout, 0);

    // Handshake on the timeout cycle: ptr=2, requester 2 idles 7 cycles then sends
    bus.req_valid = 4'b0100;
    bus.req_data[23:16] = 8'h77;
    arb_win("hto", 4'b0100);
    bus.req_valid = 4'b0000;
    for (int k = 1; k <= 7; k++) begin
      tick();
      check($sformatf("hto_wait%0d", k), bus.timeout, 0);
    end
    bus.req_valid = 4'b0100;
    #1;
    check("hto_ready", bus.req_ready, 4'b0100);
    tick();
    check("hto_we", bus.tx_we, 1);
    check("hto_din", bus.tx_din, 8'h77);
    check("hto_no_to", bus.timeout, 0);
    check("hto_grant", bus.grant, 4'b0100);
    bus.tx_busy = 1'b1;
    tick();
    check("hto_wait_done", bus.active, 1);

    // Reset in WAIT_DONE with the transmitter still busy
    rst = 1'b1;
    bus.req_valid = 4'b1111;
    tick();
    check("mrst_grant", bus.grant, 0);
    check("mrst_active", bus.active, 0);
    check("mrst_we", bus.tx_we, 0);
    check("mrst_din", bus.tx_din, 0);
    check("mrst_timeout", bus.timeout, 0);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("mrst_busy%0d", k), {bus.active, bus.grant}, 5'b0_0000);
    end
    bus.tx_busy = 1'b0;
    tick();
    check("mrst_regrant", bus.grant, 4'b0001);

    // req_ready gated by reset while in SEND
    rst = 1'b1;
    #1;
    check("rst_gate_ready", bus.req_ready, 0);
    tick();
    check("rst_gate_grant", bus.grant, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
